matrix_tx_packer: RTL

MATRIX_TX_PACKER -- requirements
Module: matrix_tx_packer

---
 rtl/matrix_tx_packer_pkg.sv | 23 ++
 rtl/matrix_tx_packer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/matrix_tx_packer_pkg.sv
// Matrix frame protocol constants and FSM encoding shared by the matrix
// transmit packer and receive handler.
package matrix_tx_packer_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MAX_DIM           = 5;
  localparam int unsigned HDR_LEN           = 4;
  localparam int unsigned N_ELEM            = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

  function automatic logic dim_ok(input logic [2:0] dim);
    return (dim != 3'd0) && (dim <= 3'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_tx_packer.sv
// Serialises one stored matrix into a sync/header/elements/checksum byte
// frame, handshaking each byte with a UART transmitter.
module matrix_tx_packer
  import matrix_tx_packer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] matrix_idx,
  input  logic [2:0] matrix_row,
  input  logic [2:0] matrix_col,
  input  logic [7:0] d0,  d1,  d2,  d3,  d4,
  input  logic [7:0] d5,  d6,  d7,  d8,  d9,
  input  logic [7:0] d10, d11, d12, d13, d14,
  input  logic [7:0] d15, d16, d17, d18, d19,
  input  logic [7:0] d20, d21, d22, d23, d24,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       dim_err
);

  if (CLK_FREQ == 0) begin : g_no_clk_freq
  end

  state_t     r_state, w_next;
  logic [2:0] r_idx, r_rows, r_cols, r_row, r_col;
  logic [7:0] r_mat [N_ELEM];
  logic [5:0] r_cnt;
  logic [7:0] r_csum, r_tx_data;
  logic       r_dim_err;

  logic [7:0] w_d [N_ELEM];
  logic       w_legal, w_accept, w_load, w_is_elem;
  logic [5:0] w_total, w_last;
  logic [4:0] w_elem_idx;
  logic [7:0] w_byte;

  assign w_d = '{d0,  d1,  d2,  d3,  d4,  d5,  d6,  d7,  d8,  d9,
                 d10, d11, d12, d13, d14, d15, d16, d17, d18, d19,
                 d20, d21, d22, d23, d24};

  assign w_legal    = dim_ok(matrix_row) && dim_ok(matrix_col);
  assign w_accept   = (r_state == ST_IDLE) && start && w_legal;
  assign w_total    = 6'(r_rows) * 6'(r_cols) + 6'(HDR_LEN + 1);
  assign w_last     = w_total - 6'd1;
  assign w_is_elem  = (r_cnt >= 6'(HDR_LEN)) && (r_cnt < w_last);
  assign w_elem_idx = 5'(r_row) * 5'(MAX_DIM) + 5'(r_col);
  // Every entry into SEND loads the next frame byte into tx_data.
  assign w_load     = (w_next == ST_SEND);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_accept) w_next = ST_LOAD;
      ST_LOAD:      if (!tx_busy) w_next = ST_SEND;
      ST_SEND:      w_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tx_busy) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) w_next = (r_cnt < w_total) ? ST_SEND : ST_FINISH;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte = r_mat[w_elem_idx];
    case (r_cnt)
      6'd0:    w_byte = SYNC_BYTE;
      6'd1:    w_byte = {5'd0, r_idx};
      6'd2:    w_byte = {5'd0, r_rows};
      6'd3:    w_byte = {5'd0, r_cols};
      default: if (r_cnt == w_last) w_byte = r_csum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rows    <= '0;
      r_cols    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_cnt     <= '0;
      r_csum    <= '0;
      r_tx_data <= '0;
      r_dim_err <= 1'b0;
      for (int unsigned i = 0; i < N_ELEM; i++) r_mat[i] <= '0;
    end else begin
      r_state   <= w_next;
      r_dim_err <= (r_state == ST_IDLE) && start && !w_legal;
      if (w_accept) begin
        r_idx  <= matrix_idx;
        r_rows <= matrix_row;
        r_cols <= matrix_col;
        r_mat  <= w_d;
        r_row  <= '0;
        r_col  <= '0;
        r_cnt  <= '0;
      end
      if (r_state == ST_LOAD) r_csum <= '0;
      if (w_load) begin
        r_tx_data <= w_byte;
        r_cnt     <= r_cnt + 6'd1;
        // Sync byte and the checksum byte itself stay out of the checksum.
        if ((r_cnt != 6'd0) && (r_cnt != w_last)) r_csum <= r_csum ^ w_byte;
        if (w_is_elem) begin
          if (r_col == r_cols - 3'd1) begin
            r_col <= '0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = (r_state == ST_SEND);
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_SEND) ||
                    (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
  assign done     = (r_state == ST_FINISH);
  assign dim_err  = r_dim_err;

endmodule
